// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO and its storage.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_AF_LVL = DEF_DEPTH - 2;
  localparam int unsigned DEF_AE_LVL = 2;

  // Ceiling log2, usable in constant expressions (returns 0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: WIDTH x DEPTH register array, one write port, one async read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy, threshold flags and peak tracking.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = DEF_AE_LVL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    w_ready,
  input  logic                    w_valid,
  input  logic [WIDTH-1:0]        w_data,
  output logic                    r_ready,
  input  logic                    r_valid,
  output logic [WIDTH-1:0]        r_data,
  input  logic                    flush,
  output logic [clog2(DEPTH):0]   count,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   peak
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [AW:0]      wp, rp, cnt, pk;
  logic [AW:0]      wp_n, rp_n, cnt_n, pk_n;
  logic             full, empty, w_fire, r_fire;
  logic [WIDTH-1:0] mem_rdata;

  // Flags come only from registered pointers; wrap bit disambiguates full from empty.
  assign full    = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign empty   = (wp == rp);
  assign w_ready = ~full;
  assign r_ready = ~empty;
  assign w_fire  = w_ready & w_valid;
  assign r_fire  = r_ready & r_valid;

  // Next pointer/count/peak; flush wins over any same-cycle transfer.
  always_comb begin
    wp_n  = wp + PW'(w_fire);
    rp_n  = rp + PW'(r_fire);
    cnt_n = wp_n - rp_n;
    pk_n  = (cnt_n > pk) ? cnt_n : pk;
    if (flush) begin
      wp_n  = '0;
      rp_n  = '0;
      cnt_n = '0;
      pk_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      pk  <= '0;
    end else begin
      wp  <= wp_n;
      rp  <= rp_n;
      cnt <= cnt_n;
      pk  <= pk_n;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_fire & ~flush),
    .waddr (wp[AW-1:0]),
    .wdata (w_data),
    .raddr (rp[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign r_data       = empty ? '0 : mem_rdata;
  assign count        = cnt;
  assign peak         = pk;
  assign almost_full  = (cnt >= PW'(AF_LVL));
  assign almost_empty = (cnt <= PW'(AE_LVL));

endmodule
